// File: rtl/spi_flash_rd.sv
// spi_flash_rd: sequences a SPI NOR read (cmd 0x03) through the spi master's register bus
// and buffers the returned bytes in an RX FIFO that the CPU drains through the DATA register.
module spi_flash_rd #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dcs,
    input  logic            drd,
    input  logic            dwe,
    input  logic [1:0]      dadrs,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            irq,
    output logic            fcs_n,
    output logic            m_cs,
    output logic            m_rd,
    output logic            m_we,
    output logic [1:0]      m_adrs,
    output logic [XLEN-1:0] m_din,
    input  logic [XLEN-1:0] m_dout
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {IDLE, CS_SETUP, WR, GAP, PRQ, PCHK, FCHK, RRQ, RCAP, CS_HOLD} state_t;

    state_t          state_q;
    logic [23:0]     addr_q, waddr_q;
    logic [15:0]     len_q, len_cnt_q;
    logic [2:0]      idx_q;
    logic            irq_en_q, done_q, fcs_n_q, m_rd_q, m_we_q;
    logic [1:0]      m_adrs_q;
    logic [7:0]      m_din_q;
    logic [XLEN-1:0] dout_q;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     cnt_q;

    logic            idle, wr, rd, push, pop, start, full, nonempty;
    logic [7:0]      nxt_byte;
    logic [XLEN-1:0] status, rdata;
    logic            unused_bits;

    assign idle     = state_q == IDLE;
    assign wr       = dcs & dwe;
    assign rd       = dcs & drd;
    assign push     = state_q == RCAP;
    assign nonempty = cnt_q != '0;
    assign full     = cnt_q == (AW+1)'(DEPTH);
    assign pop      = rd && dadrs == 2'd3 && nonempty;
    assign start    = wr && dadrs == 2'd2 && din[0] && idle;
    // idx_q names the command byte just sent; this is the one that follows it
    assign nxt_byte = idx_q == 3'd0 ? waddr_q[23:16] : idx_q == 3'd1 ? waddr_q[15:8] : waddr_q[7:0];
    assign status   = XLEN'({8'(cnt_q), 3'b000, irq_en_q, full, nonempty, done_q, ~idle});
    assign rdata    = dadrs == 2'd0 ? XLEN'(addr_q) :
                      dadrs == 2'd1 ? XLEN'(len_q) :
                      dadrs == 2'd2 ? status :
                      nonempty ? XLEN'(mem[rptr_q]) : '0;

    assign dout        = dout_q;
    assign irq         = done_q & irq_en_q;
    assign fcs_n       = fcs_n_q;
    assign m_rd        = m_rd_q;
    assign m_we        = m_we_q;
    assign m_cs        = m_rd_q | m_we_q;
    assign m_adrs      = m_adrs_q;
    assign m_din       = XLEN'(m_din_q);
    assign unused_bits = ^{din[XLEN-1:24], m_dout[XLEN-1:8]};

    always_ff @(posedge clk)
        if (push) mem[wptr_q] <= m_dout[7:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            waddr_q   <= '0;
            len_q     <= '0;
            len_cnt_q <= '0;
            idx_q     <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            fcs_n_q   <= 1'b1;
            m_rd_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_adrs_q  <= '0;
            m_din_q   <= '0;
            dout_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            m_we_q   <= 1'b0;
            m_rd_q   <= 1'b0;
            m_adrs_q <= '0;
            m_din_q  <= '0;
            if (rd) dout_q <= rdata;
            if (wr && dadrs == 2'd0 && idle) addr_q <= din[23:0];
            if (wr && dadrs == 2'd1 && idle) len_q <= din[15:0];
            if (wr && dadrs == 2'd2) begin
                irq_en_q <= din[4];
                if (din[1]) done_q <= 1'b0;
            end
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop) rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            // FSM assignments come last so a start or completion overrides a same-cycle clear-done
            case (state_q)
                IDLE:
                    if (start) begin
                        if (len_q == 16'd0) done_q <= 1'b1;
                        else begin
                            done_q    <= 1'b0;
                            fcs_n_q   <= 1'b0;
                            idx_q     <= '0;
                            waddr_q   <= addr_q;
                            len_cnt_q <= len_q;
                            state_q   <= CS_SETUP;
                        end
                    end
                CS_SETUP: begin
                    m_we_q  <= 1'b1;
                    m_din_q <= 8'h03;
                    state_q <= WR;
                end
                WR: state_q <= GAP;
                GAP: begin
                    m_rd_q   <= 1'b1;
                    m_adrs_q <= 2'd1;
                    state_q  <= PRQ;
                end
                PRQ: state_q <= PCHK;
                PCHK:
                    if (!m_dout[0]) begin
                        m_rd_q   <= 1'b1;
                        m_adrs_q <= 2'd1;
                        state_q  <= PRQ;
                    end else if (idx_q < 3'd3) begin
                        idx_q   <= idx_q + 3'd1;
                        m_we_q  <= 1'b1;
                        m_din_q <= nxt_byte;
                        state_q <= WR;
                    end else if (idx_q == 3'd3) begin
                        idx_q   <= 3'd4;
                        state_q <= FCHK;
                    end else begin
                        m_rd_q  <= 1'b1;
                        state_q <= RRQ;
                    end
                // only one byte is ever in flight, so a free slot here guarantees room at RCAP
                FCHK:
                    if (len_cnt_q == 16'd0) state_q <= CS_HOLD;
                    else if (cnt_q < (AW+1)'(DEPTH)) begin
                        m_we_q  <= 1'b1;
                        m_din_q <= 8'hFF;
                        state_q <= WR;
                    end
                RRQ: state_q <= RCAP;
                RCAP: begin
                    len_cnt_q <= len_cnt_q - 16'd1;
                    state_q   <= FCHK;
                end
                CS_HOLD: begin
                    fcs_n_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_rd.sv
// tb_spi_flash_rd: directed bench with a spi master + flash model; returned bytes are
// queued as expected results and checked as the CPU pops them from DATA.
module tb_spi_flash_rd;
    logic        clk = 0, rstn = 0, dcs = 0, drd = 0, dwe = 0;
    logic [1:0]  dadrs = 0;
    logic [31:0] din = 0, m_dout = 0;
    logic [31:0] dout, m_din;
    logic        irq, fcs_n, m_cs, m_rd, m_we;
    logic [1:0]  m_adrs;

    int          checks = 0, failures = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] tx_log[$];
    int          mcs_cnt = 0, fcs_low_cnt = 0, cs_err = 0, we_cnt = 0, rrq_cnt = 0, busy_cnt = 0, widx = 0;
    logic [7:0]  base = 8'hA0, rx = 0;

    always #5 clk = ~clk;

    spi_flash_rd #(.XLEN(32), .DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .dcs(dcs), .drd(drd), .dwe(dwe), .dadrs(dadrs), .din(din),
        .dout(dout), .irq(irq), .fcs_n(fcs_n), .m_cs(m_cs), .m_rd(m_rd), .m_we(m_we),
        .m_adrs(m_adrs), .m_din(m_din), .m_dout(m_dout)
    );

    // spi master + flash model: status bit0 = idle, busy 3 cycles after each data write
    always @(negedge clk) begin
        if (!rstn) begin
            busy_cnt = 0;
            widx = 0;
            m_dout = 0;
            exp_q.delete();
        end else begin
            if (m_cs) mcs_cnt++;
            if (!fcs_n) fcs_low_cnt++;
            if ((m_we || m_rd) && fcs_n) cs_err++;
            if (m_we) begin
                tx_log.push_back(m_din);
                we_cnt++;
                busy_cnt = 3;
                rx = widx >= 4 ? base + 8'(widx - 4) : 8'h00;
                widx++;
            end else if (busy_cnt > 0) busy_cnt--;
            if (m_rd) begin
                if (m_adrs == 2'd1) m_dout = {31'b0, busy_cnt == 0};
                else begin
                    m_dout = {24'b0, rx};
                    rrq_cnt++;
                    exp_q.push_back(rx);
                end
            end
            if (fcs_n) widx = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
        dcs = 1; dwe = 1; dadrs = a; din = d;
        @(negedge clk);
        dcs = 0; dwe = 0;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [31:0] v);
        dcs = 1; drd = 1; dadrs = a;
        @(negedge clk);
        dcs = 0; drd = 0;
        v = dout;
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] v, e;
        e = exp_q.size() != 0 ? {24'b0, exp_q.pop_front()} : 32'h0;
        cpu_rd(2'd3, v);
        chk(tag, v, e);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        v = 32'h1;
        for (int i = 0; i < 1000 && v[0]; i++) cpu_rd(2'd2, v);
        chk(tag, {31'b0, v[0]}, 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp2 [8] = '{32'h03, 32'h01, 32'h23, 32'h45, 32'hFF, 32'hFF, 32'hFF, 32'hFF};
        logic [31:0] exp5 [5] = '{32'h03, 32'h00, 32'h02, 32'h00, 32'hFF};
        int s_mcs, s_fcs, s_err, s_tx, s_we, s_rrq, n, k;

        // 1: reset state
        repeat (3) @(negedge clk);
        rstn = 1;
        chk("rst_dout", dout, 0);
        chk("rst_fcs_n", {31'b0, fcs_n}, 1);
        chk("rst_irq", {31'b0, irq}, 0);
        s_mcs = mcs_cnt;
        cpu_rd(2'd2, v);
        chk("rst_status", v, 0);
        repeat (20) @(negedge clk);
        chk("rst_no_mcs", mcs_cnt - s_mcs, 0);

        // 2: 4-byte read at 0x012345
        base = 8'hA0; s_tx = tx_log.size(); s_err = cs_err;
        cpu_wr(2'd0, 32'h0001_2345);
        cpu_wr(2'd1, 32'd4);
        cpu_wr(2'd2, 32'h1);
        wait_idle("t2_idle");
        chk("t2_tx_count", tx_log.size() - s_tx, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_tx%0d", i), tx_log[s_tx + i], exp2[i]);
        chk("t2_cs_low", cs_err - s_err, 0);
        chk("t2_fcs_n_end", {31'b0, fcs_n}, 1);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("t2_data%0d", i));
        pop_chk("t2_empty_data");
        cpu_rd(2'd2, v);
        chk("t2_status", v, 32'h02);

        // 3: LEN=20 stalls on a full FIFO
        base = 8'h40; s_rrq = rrq_cnt;
        cpu_wr(2'd0, 32'h0000_0100);
        cpu_wr(2'd1, 32'd20);
        cpu_wr(2'd2, 32'h1);
        for (int i = 0; i < 3000 && rrq_cnt - s_rrq < 16; i++) @(negedge clk);
        s_we = we_cnt;
        repeat (60) @(negedge clk);
        chk("t3_pushes16", rrq_cnt - s_rrq, 16);
        chk("t3_no_we", we_cnt - s_we, 0);
        chk("t3_fcs_low", {31'b0, fcs_n}, 0);
        cpu_rd(2'd2, v);
        chk("t3_status_full", v, 32'h100D);
        pop_chk("t3_pop0");
        repeat (100) @(negedge clk);
        chk("t3_one_more", rrq_cnt - s_rrq, 17);
        cpu_rd(2'd2, v);
        chk("t3_status_refull", v, 32'h100D);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            cpu_rd(2'd2, v);
            if (v[2]) begin
                pop_chk($sformatf("t3_data%0d", n + 1));
                n++;
            end else if (!v[0]) break;
        end
        chk("t3_drained", n, 19);
        chk("t3_total", rrq_cnt - s_rrq, 20);
        chk("t3_sb_empty", exp_q.size(), 0);

        // 4: LEN=0 completes without bus activity
        s_mcs = mcs_cnt; s_fcs = fcs_low_cnt;
        cpu_wr(2'd1, 32'd0);
        cpu_wr(2'd2, 32'h1);
        cpu_rd(2'd2, v);
        chk("t4_status", v, 32'h02);
        repeat (10) @(negedge clk);
        chk("t4_no_mcs", mcs_cnt - s_mcs, 0);
        chk("t4_no_fcs", fcs_low_cnt - s_fcs, 0);

        // 5: irq, start/ADDR write while busy ignored, clear-done drops irq
        base = 8'h77; s_tx = tx_log.size();
        cpu_wr(2'd2, 32'h12);
        chk("t5_irq_cleared", {31'b0, irq}, 0);
        cpu_wr(2'd0, 32'h0000_0200);
        cpu_wr(2'd1, 32'd1);
        cpu_wr(2'd2, 32'h11);
        cpu_wr(2'd2, 32'h11);
        cpu_wr(2'd0, 32'h00AB_CDEF);
        for (int i = 0; i < 1000 && !irq; i++) @(negedge clk);
        chk("t5_irq", {31'b0, irq}, 1);
        chk("t5_fcs_n_at_irq", {31'b0, fcs_n}, 1);
        chk("t5_tx_count", tx_log.size() - s_tx, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t5_tx%0d", i), tx_log[s_tx + i], exp5[i]);
        cpu_rd(2'd2, v);
        chk("t5_status", v, 32'h116);
        cpu_rd(2'd0, v);
        chk("t5_addr_kept", v, 32'h200);
        cpu_wr(2'd2, 32'h12);
        chk("t5_irq_drop", {31'b0, irq}, 0);

        // 6: reset during the third command byte (FIFO still holds 0x77)
        cpu_wr(2'd0, 32'h0000_ABCD);
        cpu_wr(2'd1, 32'd2);
        cpu_wr(2'd2, 32'h1);
        k = 0;
        for (int i = 0; i < 500 && k < 3; i++) begin
            @(negedge clk);
            if (m_we) k++;
        end
        chk("t6_third_byte", k, 3);
        rstn = 0;
        @(negedge clk);
        chk("t6_fcs_n", {31'b0, fcs_n}, 1);
        chk("t6_mcs", {31'b0, m_cs}, 0);
        rstn = 1;
        cpu_rd(2'd2, v);
        chk("t6_status", v, 0);
        pop_chk("t6_data_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
